// File: rtl/router_fsm_np.sv
// Router controller FSM: decodes the header address, steers one packet stream into one of
// NUM_PORTS output FIFOs, and handles full stalls, empty-wait timeout and invalid-address drops.
module router_fsm_np #(
    parameter int NUM_PORTS    = 3,
    parameter int ADDR_W       = 2,
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    output logic                 busy,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 write_enb_reg,
    output logic                 rst_int_reg,
    output logic [NUM_PORTS-1:0] dest_sel,
    output logic                 addr_err,
    output logic                 timeout_err
);

    typedef enum logic [3:0] {
        DecodeAddress,
        LoadFirstData,
        LoadData,
        LoadParity,
        FifoFullState,
        LoadAfterFull,
        WaitTillEmpty,
        CheckParityError,
        DropPacket
    } state_t;

    localparam int CNT_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT : 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);
    // One extra bit so the compare also works when 2**ADDR_W == NUM_PORTS.
    localparam logic [ADDR_W:0]  PORTS_W  = (ADDR_W + 1)'(NUM_PORTS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] hdr_oh, cur_oh, dest_d;

    function automatic logic [NUM_PORTS-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [NUM_PORTS-1:0] oh;
        for (int i = 0; i < NUM_PORTS; i++) begin
            oh[i] = (a == ADDR_W'(i));
        end
        return oh;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hdr_oh  = onehot(data_in);
        cur_oh  = onehot(addr_q);

        case (state_q)
            DecodeAddress: begin
                if (pkt_valid) begin
                    addr_d = data_in;
                    if ({1'b0, data_in} >= PORTS_W) begin
                        state_d = DropPacket;
                    end else if (|(fifo_empty & hdr_oh)) begin
                        state_d = LoadFirstData;
                    end else begin
                        state_d = WaitTillEmpty;
                        cnt_d   = '0;
                    end
                end
            end
            LoadFirstData: state_d = LoadData;
            LoadData: begin
                if (fifo_full) begin
                    state_d = FifoFullState;
                end else if (!pkt_valid) begin
                    state_d = LoadParity;
                end
            end
            FifoFullState: begin
                if (!fifo_full) begin
                    state_d = LoadAfterFull;
                end
            end
            LoadAfterFull: begin
                if (parity_done) begin
                    state_d = DecodeAddress;
                end else if (low_pkt_valid) begin
                    state_d = LoadParity;
                end else begin
                    state_d = LoadData;
                end
            end
            LoadParity: state_d = CheckParityError;
            CheckParityError: state_d = fifo_full ? FifoFullState : DecodeAddress;
            WaitTillEmpty: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Draining on the last allowed cycle still beats the timeout.
                if (|(fifo_empty & cur_oh)) begin
                    state_d = LoadFirstData;
                end else if ((WAIT_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d = DropPacket;
                end
            end
            DropPacket: begin
                if (!pkt_valid) begin
                    state_d = DecodeAddress;
                end
            end
            default: state_d = DecodeAddress;
        endcase

        if ((state_q != DecodeAddress) && (state_q != DropPacket) && |(soft_reset & cur_oh)) begin
            state_d = DecodeAddress;
        end

        dest_d = ((state_d == DecodeAddress) || (state_d == DropPacket)) ? '0 : onehot(addr_d);
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= DecodeAddress;
            addr_q        <= '0;
            cnt_q         <= '0;
            busy          <= 1'b0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            write_enb_reg <= 1'b0;
            rst_int_reg   <= 1'b0;
            dest_sel      <= '0;
            addr_err      <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            busy          <= (state_d == LoadFirstData) || (state_d == LoadParity) ||
                             (state_d == FifoFullState) || (state_d == LoadAfterFull) ||
                             (state_d == WaitTillEmpty) || (state_d == CheckParityError);
            detect_add    <= (state_d == DecodeAddress);
            lfd_state     <= (state_d == LoadFirstData);
            ld_state      <= (state_d == LoadData);
            laf_state     <= (state_d == LoadAfterFull);
            full_state    <= (state_d == FifoFullState);
            write_enb_reg <= (state_d == LoadData) || (state_d == LoadParity) ||
                             (state_d == LoadAfterFull);
            rst_int_reg   <= (state_d == CheckParityError);
            dest_sel      <= dest_d;
            addr_err      <= (state_q == DecodeAddress) && (state_d == DropPacket);
            timeout_err   <= (state_q == WaitTillEmpty) && (state_d == DropPacket);
        end
    end

endmodule

// File: tb/tb_router_fsm_np.sv
// Scoreboard bench for router_fsm_np: a 3-port instance (WAIT_TIMEOUT=4) and a 5-port instance.
module tb_router_fsm_np;

    localparam int DA = 0, LFD = 1, LD = 2, LP = 3, FF = 4, LAF = 5, WTE = 6, CPE = 7, DRP = 8;

    typedef struct {
        string       nm;
        int          which;
        logic [14:0] v;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    logic clock = 1'b0;
    logic resetn = 1'b0;

    logic       pv = 0, pd = 0, lpv = 0, full = 0;
    logic [1:0] din = '0;
    logic [2:0] emp = '0, srst = '0;
    logic       busy3, det3, lfd3, ld3, laf3, fst3, wen3, rst3, aerr3, terr3;
    logic [2:0] dsel3;

    logic       pv5 = 0, pd5 = 0, lpv5 = 0, full5 = 0;
    logic [2:0] din5 = '0;
    logic [4:0] emp5 = '0, srst5 = '0;
    logic       busy5, det5, lfd5, ld5, laf5, fst5, wen5, rst5, aerr5, terr5;
    logic [4:0] dsel5;

    logic [14:0] o3, o5;
    assign o3 = {busy3, det3, lfd3, ld3, laf3, fst3, wen3, rst3, aerr3, terr3, 2'b00, dsel3};
    assign o5 = {busy5, det5, lfd5, ld5, laf5, fst5, wen5, rst5, aerr5, terr5, dsel5};

    always #5 clock = ~clock;

    router_fsm_np #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_TIMEOUT(4)) dut3 (
        .clock(clock), .resetn(resetn), .pkt_valid(pv), .data_in(din), .parity_done(pd),
        .low_pkt_valid(lpv), .fifo_full(full), .fifo_empty(emp), .soft_reset(srst),
        .busy(busy3), .detect_add(det3), .lfd_state(lfd3), .ld_state(ld3), .laf_state(laf3),
        .full_state(fst3), .write_enb_reg(wen3), .rst_int_reg(rst3), .dest_sel(dsel3),
        .addr_err(aerr3), .timeout_err(terr3)
    );

    router_fsm_np #(.NUM_PORTS(5), .ADDR_W(3), .WAIT_TIMEOUT(16)) dut5 (
        .clock(clock), .resetn(resetn), .pkt_valid(pv5), .data_in(din5), .parity_done(pd5),
        .low_pkt_valid(lpv5), .fifo_full(full5), .fifo_empty(emp5), .soft_reset(srst5),
        .busy(busy5), .detect_add(det5), .lfd_state(lfd5), .ld_state(ld5), .laf_state(laf5),
        .full_state(fst5), .write_enb_reg(wen5), .rst_int_reg(rst5), .dest_sel(dsel5),
        .addr_err(aerr5), .timeout_err(terr5)
    );

    // Expected Moore outputs for a state, hand-listed from the output table.
    function automatic logic [14:0] ev(int st, int a, logic ae, logic te);
        logic [14:0] v;
        v     = '0;
        v[14] = (st == LFD) || (st == LP) || (st == FF) || (st == LAF) || (st == WTE) ||
                (st == CPE);
        v[13] = (st == DA);
        v[12] = (st == LFD);
        v[11] = (st == LD);
        v[10] = (st == LAF);
        v[9]  = (st == FF);
        v[8]  = (st == LD) || (st == LP) || (st == LAF);
        v[7]  = (st == CPE);
        v[6]  = ae;
        v[5]  = te;
        if (st != DA && st != DRP) v[a] = 1'b1;
        return v;
    endfunction

    task automatic push(input string nm, input int which, input int st, input int a,
                        input logic ae, input logic te);
        exp_t e;
        e.nm    = nm;
        e.which = which;
        e.v     = ev(st, a, ae, te);
        q.push_back(e);
    endtask

    // One clock edge, then queue what the outputs must show after it.
    task automatic tick(input string nm, input int which, input int st, input int a,
                        input logic ae, input logic te);
        @(posedge clock);
        #1;
        push(nm, which, st, a, ae, te);
    endtask

    always @(negedge clock) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [14:0] act;
            e       = q.pop_front();
            act     = (e.which == 3) ? o3 : o5;
            n_total = n_total + 1;
            if (act !== e.v) begin
                $display("FAIL %s (dut%0d): got %b, expected %b", e.nm, e.which, act, e.v);
            end else begin
                n_pass = n_pass + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        push("reset3", 3, DA, 0, 0, 0);
        push("reset5", 5, DA, 0, 0, 0);
        @(negedge clock);
        #1 resetn = 1'b1;

        tick("idle", 3, DA, 0, 0, 0);

        // Basic packet to port 0.
        pv = 1; din = 2'd0; emp = 3'b001;
        tick("p0_lfd", 3, LFD, 0, 0, 0);
        tick("p0_ld1", 3, LD, 0, 0, 0);
        tick("p0_ld2", 3, LD, 0, 0, 0);
        pv = 0;
        tick("p0_lp", 3, LP, 0, 0, 0);
        tick("p0_cpe", 3, CPE, 0, 0, 0);
        tick("p0_da", 3, DA, 0, 0, 0);

        // Port 2 with full stalls and both LOAD_AFTER_FULL branches.
        pv = 1; din = 2'd2; emp = 3'b100;
        tick("p2_lfd", 3, LFD, 2, 0, 0);
        tick("p2_ld1", 3, LD, 2, 0, 0);
        tick("p2_ld2", 3, LD, 2, 0, 0);
        tick("p2_ld3", 3, LD, 2, 0, 0);
        full = 1;
        tick("p2_ff", 3, FF, 2, 0, 0);
        full = 0;
        tick("p2_laf", 3, LAF, 2, 0, 0);
        tick("p2_laf_ld", 3, LD, 2, 0, 0);
        full = 1;
        tick("p2_ff2", 3, FF, 2, 0, 0);
        full = 0;
        tick("p2_laf2", 3, LAF, 2, 0, 0);
        lpv = 1;
        tick("p2_laf_lp", 3, LP, 2, 0, 0);
        lpv = 0; pv = 0;
        tick("p2_cpe", 3, CPE, 2, 0, 0);
        tick("p2_da", 3, DA, 2, 0, 0);

        // parity_done out of LOAD_AFTER_FULL.
        pv = 1; din = 2'd1; emp = 3'b010;
        tick("p1_lfd", 3, LFD, 1, 0, 0);
        tick("p1_ld", 3, LD, 1, 0, 0);
        full = 1;
        tick("p1_ff", 3, FF, 1, 0, 0);
        full = 0;
        tick("p1_laf", 3, LAF, 1, 0, 0);
        pd = 1; pv = 0;
        tick("p1_pd_da", 3, DA, 1, 0, 0);
        pd = 0;

        // Invalid address 3: drop with a single addr_err pulse.
        pv = 1; din = 2'd3; emp = 3'b111;
        tick("bad_drop", 3, DRP, 0, 1, 0);
        for (int i = 0; i < 4; i++) tick("bad_hold", 3, DRP, 0, 0, 0);
        pv = 0;
        tick("bad_da", 3, DA, 0, 0, 0);

        // Wait-till-empty timeout.
        pv = 1; din = 2'd1; emp = 3'b000;
        tick("to_wte1", 3, WTE, 1, 0, 0);
        pv = 0;
        for (int i = 0; i < 3; i++) tick("to_wte", 3, WTE, 1, 0, 0);
        tick("to_drop", 3, DRP, 0, 0, 1);
        tick("to_da", 3, DA, 0, 0, 0);

        // FIFO drains on the final wait cycle: no timeout.
        pv = 1; din = 2'd1; emp = 3'b000;
        tick("dr_wte1", 3, WTE, 1, 0, 0);
        pv = 0;
        for (int i = 0; i < 3; i++) tick("dr_wte", 3, WTE, 1, 0, 0);
        emp = 3'b010;
        tick("dr_lfd", 3, LFD, 1, 0, 0);
        tick("dr_ld", 3, LD, 1, 0, 0);
        tick("dr_lp", 3, LP, 1, 0, 0);
        tick("dr_cpe", 3, CPE, 1, 0, 0);
        tick("dr_da", 3, DA, 1, 0, 0);

        // Soft reset: foreign port ignored, own port aborts.
        pv = 1; din = 2'd2; emp = 3'b100;
        tick("sr_lfd", 3, LFD, 2, 0, 0);
        tick("sr_ld", 3, LD, 2, 0, 0);
        srst = 3'b001;
        tick("sr_other", 3, LD, 2, 0, 0);
        srst = 3'b100; pv = 0;
        tick("sr_own", 3, DA, 2, 0, 0);
        srst = 3'b000;
        tick("sr_idle", 3, DA, 2, 0, 0);

        // Async reset between edges while stalled full.
        pv = 1; din = 2'd0; emp = 3'b001;
        tick("ar_lfd", 3, LFD, 0, 0, 0);
        tick("ar_ld", 3, LD, 0, 0, 0);
        full = 1;
        tick("ar_ff", 3, FF, 0, 0, 0);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        push("ar_reset3", 3, DA, 0, 0, 0);
        push("ar_reset5", 5, DA, 0, 0, 0);
        @(negedge clock);
        #1;
        pv = 0; full = 0; emp = 3'b000;
        resetn = 1'b1;

        // Five-port instance: highest valid port, then first invalid address.
        pv5 = 1; din5 = 3'd4; emp5 = 5'b10000;
        tick("n5_lfd", 5, LFD, 4, 0, 0);
        tick("n5_ld", 5, LD, 4, 0, 0);
        pv5 = 0;
        tick("n5_lp", 5, LP, 4, 0, 0);
        tick("n5_cpe", 5, CPE, 4, 0, 0);
        tick("n5_da", 5, DA, 4, 0, 0);
        pv5 = 1; din5 = 3'd5; emp5 = 5'b11111;
        tick("n5_drop", 5, DRP, 0, 1, 0);
        pv5 = 0;
        tick("n5_back", 5, DA, 0, 0, 0);

        @(negedge clock);
        #1;
        n_total = n_total + 1;
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end else begin
            n_pass = n_pass + 1;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
- Parametrised successor to the 1x3 router controller FSM; steers one input packet stream to one of NUM_PORTS output FIFOs.
- Decodes the header address and sequences the header, payload and parity loads, FIFO-full stalls and parity check.
- New over the fixed 3-port FSM: any port count; invalid-address packet drop; bounded wait-till-empty with timeout abort; latched one-hot destination select.
- Sits between the input register/parity block and the FIFO synchroniser.

Parameters:
NUM_PORTS, 3, number of output channels (>=2).
ADDR_W, 2, header address field width; 2**ADDR_W >= NUM_PORTS.
WAIT_TIMEOUT, 16, maximum cycles spent in WAIT_TILL_EMPTY before abort; 0 disables the timeout.

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  asynchronous active-low reset.
pkt_valid  in  1  source packet valid.
data_in  in  ADDR_W  header address bits (data byte LSBs).
parity_done  in  1  parity byte loaded.
low_pkt_valid  in  1  pkt_valid fell while stalled.
fifo_full  in  1  full flag of the selected FIFO.
fifo_empty  in  NUM_PORTS  per-port FIFO empty.
soft_reset  in  NUM_PORTS  per-port read-timeout soft reset.
busy  out  1  stall the source.
detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg  out  1 each  state decodes.
dest_sel  out  NUM_PORTS  one-hot latched destination.
addr_err  out  1  one-cycle pulse: packet dropped, address >= NUM_PORTS.
timeout_err  out  1  one-cycle pulse: packet dropped, wait timed out.

Behaviour:
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR, DROP_PACKET.
- Reset (async, resetn=0):
  - state=DECODE_ADDRESS; addr_reg=0; wait counter=0; addr_err=timeout_err=0.
  - Outputs: detect_add=1, all other outputs 0, dest_sel=0.
- DECODE_ADDRESS, when pkt_valid=1: addr_reg<=data_in, then:
  - data_in >= NUM_PORTS -> DROP_PACKET, addr_err=1 next cycle.
  - fifo_empty[data_in]=1 -> LOAD_FIRST_DATA.
  - otherwise -> WAIT_TILL_EMPTY, counter cleared.
  - pkt_valid=0: stay.
- LOAD_FIRST_DATA -> LOAD_DATA, unconditionally.
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE.
  - else !pkt_valid -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - else low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- WAIT_TILL_EMPTY, counter increments each cycle:
  - fifo_empty[addr_reg] -> LOAD_FIRST_DATA. Empty wins over timeout on the same cycle.
  - else WAIT_TIMEOUT!=0 and counter==WAIT_TIMEOUT-1 -> DROP_PACKET, timeout_err=1 next cycle.
  - Counter width is clog2(WAIT_TIMEOUT+1); the counter saturates and never wraps.
- DROP_PACKET: busy=0, no writes; !pkt_valid -> DECODE_ADDRESS; else stay, discarding bytes.
- Soft reset:
  - In any state other than DECODE_ADDRESS or DROP_PACKET, soft_reset[addr_reg]=1 -> DECODE_ADDRESS next cycle.
  - Overrides all other transitions. Other ports' soft_reset bits are ignored.
- Priority: resetn > soft reset > normal transitions.
- Moore outputs:
  - busy=1 in LOAD_FIRST_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR; 0 in DECODE_ADDRESS, LOAD_DATA, DROP_PACKET.
  - write_enb_reg=1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL.
  - rst_int_reg=1 in CHECK_PARITY_ERROR.
  - detect_add / lfd_state / ld_state / laf_state / full_state each =1 only in its own state.
- dest_sel = one-hot(addr_reg) in every state except DECODE_ADDRESS and DROP_PACKET, where it is 0.
- addr_err and timeout_err are registered and high exactly on the first DROP_PACKET cycle.
- Decode latency: header seen at edge N; lfd_state high in cycle N+1 when the FIFO is empty.

Test Plan:
- NUM_PORTS=3: reset, pkt_valid=1, data_in=0, fifo_empty=3'b001 -> LOAD_FIRST_DATA next cycle, dest_sel=001, busy=1; then ld_state=1, write_enb_reg=1; pkt_valid=0 -> LOAD_PARITY, CHECK_PARITY_ERROR, DECODE_ADDRESS.
- data_in=2 with fifo_empty[2]=1, 3 payload cycles, then fifo_full=1 for 1 cycle -> full_state=1, busy=1, then laf_state=1. Cover both branches: parity_done=0 with low_pkt_valid=1 -> LOAD_PARITY; low_pkt_valid=0 -> LOAD_DATA.
- data_in=3 (NUM_PORTS=3), pkt_valid=1 for 5 cycles -> DROP_PACKET, addr_err pulses 1 cycle, busy=0, write_enb_reg=0 throughout; returns to DECODE_ADDRESS the cycle after pkt_valid=0.
- WAIT_TIMEOUT=4, data_in=1, fifo_empty[1]=0:
  - Held non-empty -> DROP_PACKET after 4 wait cycles, timeout_err=1.
  - Rerun with fifo_empty[1]=1 on wait cycle 4 -> LOAD_FIRST_DATA, no timeout_err.
- Mid-packet soft_reset[2]=1 in LOAD_DATA with addr_reg=2 -> DECODE_ADDRESS next cycle. soft_reset[0]=1 in the same situation -> no effect.
- resetn=0 asserted mid-FIFO_FULL_STATE between clock edges -> outputs reset immediately (detect_add=1, busy=0, dest_sel=0). Also run with NUM_PORTS=5, ADDR_W=3 and data_in=4 to cover the generalised port count.
